// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types, register map and helpers for irq_controller
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_VECTOR  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int CTRL_GEN_OFFSET      = 0;
  localparam int VEC_INSERVICE_OFFSET = 15;
  localparam int MAX_SRC              = 16;
  localparam int VEC_W                = 4;

  // Index following 'last', wrapping at n sources
  function automatic logic [VEC_W-1:0] next_index(input logic [VEC_W-1:0] last, input int n);
    if (int'(last) + 1 >= n) return '0;
    return last + 1'b1;
  endfunction

endpackage

// File: rtl/irq_priority_picker.sv
// rtl/irq_priority_picker.sv - find-first set candidate, searching upward from a start index with wrap
module irq_priority_picker
  import irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     cand,
  input  logic [VEC_W-1:0] start,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  int pos;

  // Walk N positions from start, wrapping at N; first set candidate wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!valid && (|(cand & (N'(1) << pos)))) begin
        valid = 1'b1;
        idx   = VEC_W'(pos);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - interrupt collector/arbiter with CPU handshake; IRQ_ROUND_ROBIN_EN selects rotating priority
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         addr,
  input  logic [15:0]        write_data,
  input  logic               write_en,
  input  logic               read_en,
  input  logic               chipselect,
  output logic [15:0]        read_data,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   cpu_vector,
  input  logic               cpu_ack
);

  irq_state_e         state, state_n;
  logic [NUM_SRC-1:0] pending, enable, prev_src;
  logic [NUM_SRC-1:0] rise, cand, vec_onehot, w1c, ack_clr;
  logic [VEC_W-1:0]   vector, start_idx, pick_idx;
  logic               pick_valid, gen, wr, rd, eoi, ack_take, vec_load;
  logic [15:0]        rd_mux;
  logic               unused_bits;

  assign wr          = chipselect && write_en;
  assign rd          = chipselect && read_en;
  assign eoi         = wr && (addr == REG_VECTOR);
  assign rise        = irq_src & ~prev_src;
  assign cand        = pending & enable;
  assign vec_onehot  = NUM_SRC'(1) << vector;
  assign w1c         = (wr && addr == REG_PENDING) ? write_data[NUM_SRC-1:0] : '0;
  assign ack_clr     = ack_take ? vec_onehot : '0;
  assign cpu_vector  = vector;
  assign unused_bits = &{1'b0, write_data};

  irq_priority_picker #(.N(NUM_SRC)) u_picker (
    .cand  (cand),
    .start (start_idx),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef IRQ_ROUND_ROBIN_EN
  logic [VEC_W-1:0] last_acked;

  // Remember the last accepted source so the search starts just past it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      last_acked <= VEC_W'(NUM_SRC - 1);
    else if (ack_take) last_acked <= vector;
  end

  assign start_idx = next_index(last_acked, NUM_SRC);
`else
  assign start_idx = '0;
`endif

  // Next-state logic; only registered pending/enable/GEN are observed
  always_comb begin
    state_n  = state;
    ack_take = 1'b0;
    vec_load = 1'b0;
    case (state)
      IDLE: begin
        if (gen && pick_valid) begin
          state_n  = REQ;
          vec_load = 1'b1;
        end
      end
      REQ: begin
        if (cpu_ack) begin
          state_n  = SERVICE;
          ack_take = 1'b1;
        end else if (!gen || !(|(pending & vec_onehot)) || !(|(enable & vec_onehot))) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, registered request line and latched winner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cpu_irq <= 1'b0;
      vector  <= '0;
    end else begin
      state   <= state_n;
      cpu_irq <= (state_n == REQ);
      if (vec_load) vector <= pick_idx;
    end
  end

  // Edge capture and software-visible registers; a new rise beats any clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_src <= '0;
      pending  <= '0;
      enable   <= '0;
      gen      <= 1'b0;
    end else begin
      prev_src <= irq_src;
      pending  <= (pending & ~w1c & ~ack_clr) | rise;
      if (wr && addr == REG_ENABLE)  enable <= write_data[NUM_SRC-1:0];
      if (wr && addr == REG_CONTROL) gen    <= write_data[CTRL_GEN_OFFSET];
    end
  end

  // Read multiplexer over current register contents
  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_PENDING: rd_mux = 16'(pending);
      REG_ENABLE:  rd_mux = 16'(enable);
      REG_VECTOR: begin
        rd_mux[VEC_W-1:0]           = vector;
        rd_mux[VEC_INSERVICE_OFFSET] = (state == SERVICE);
      end
      default:     rd_mux[CTRL_GEN_OFFSET] = gen;
    endcase
  end

  // Registered read data, held when not strobed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) read_data <= '0;
    else if (rd)  read_data <= rd_mux;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Peribus peripheral that collects interrupt lines from up to 16 sources (Timer irq outputs and similar), latches them as pending, masks them, and selects one winner.
- Presents the winner to the CPU through a registered request/acknowledge/end-of-interrupt handshake.
- Sits between the peripheral irq outputs and the core's single interrupt input.

Parameters:
- NUM_SRC, 8, number of interrupt sources (legal range 1..16); unused register bits read 0.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- addr  input  2  register select
- write_data  input  16  Peribus write data
- write_en  input  1  Peribus write strobe
- read_en  input  1  Peribus read strobe
- chipselect  input  1  peripheral select; reads and writes are ignored when low
- read_data  output  16  registered read data
- irq_src  input  NUM_SRC  level interrupt inputs from peripherals
- cpu_irq  output  1  interrupt request to the core
- cpu_vector  output  4  index of the requesting source; valid while cpu_irq=1 and in SERVICE
- cpu_ack  input  1  single-cycle pulse from the core accepting the request

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset values: read_data=0, cpu_irq=0, cpu_vector=0, pending=0, enable=0, control=0, prev_src=0, state=IDLE.
- Register map:
  - 0 PENDING: read pending[NUM_SRC-1:0]; write 1 clears that bit, write 0 has no effect.
  - 1 ENABLE: read/write mask.
  - 2 VECTOR: read {in_service(bit15), 11'h0, vector[3:0]}; any write is EOI.
  - 3 CONTROL: bit0 global enable (GEN); other bits read 0.
- Reads: when chipselect && read_en, read_data is updated on the next clock edge (1-cycle latency). Otherwise read_data holds its value.
- Edge capture:
  - prev_src <= irq_src each cycle; rise = irq_src & ~prev_src.
  - rise[i] sets pending[i] regardless of enable or GEN.
  - Because prev_src resets to 0, a source high at reset release registers as a rise in the first cycle.
  - A rise and a W1C clear on the same bit in the same cycle: the set wins.
- Arbitration: candidates = pending & enable, considered only when GEN=1. Fixed priority: lowest index wins.
- FSM:
  - IDLE:
    - If GEN and candidates≠0, latch winner into vector and go to REQ; cpu_irq rises in the same edge (registered output).
  - REQ: cpu_irq=1, cpu_vector=vector.
    - cpu_ack: clear pending[vector], cpu_irq<=0, go to SERVICE.
    - Withdraw: if pending[vector] or enable[vector] becomes 0 (or GEN=0) before ack, cpu_irq<=0 and go to IDLE.
    - cpu_ack and withdraw in the same cycle: ack wins.
    - No preemption: a higher-priority source arriving during REQ does not change vector.
    - cpu_ack outside REQ is ignored.
  - SERVICE: in_service=1, cpu_irq=0.
    - EOI write: go to IDLE; arbitration resumes the following cycle.
    - Clearing GEN does not abort SERVICE.
    - EOI written in IDLE or REQ is ignored.
- Register write priority: a bus write to ENABLE/CONTROL takes effect on the edge; the FSM samples the new value the following cycle.
- Reset mid-operation: all state returns to reset values immediately; cpu_irq drops asynchronously.

Optional Feature:
- IRQ_ROUND_ROBIN_EN defined: rotating priority. The search starts at (last_acked+1) mod NUM_SRC. last_acked is updated on cpu_ack and resets to NUM_SRC-1, so the first search starts at 0.
- Undefined: fixed priority as above, with no last_acked register.

Decomposition:
- Package irq_pkg:
  - state enum {IDLE, REQ, SERVICE};
  - register addresses (REG_PENDING=0, REG_ENABLE=1, REG_VECTOR=2, REG_CONTROL=3);
  - bit offsets (CTRL_GEN_OFFSET=0, VEC_INSERVICE_OFFSET=15);
  - MAX_SRC=16; VEC_W=4.
- Sub-module irq_priority_picker: combinational find-first over candidates with a start index. Outputs a 4-bit index and a valid flag. Start index is tied to 0 in fixed mode.

Test Plan:
- Basic: enable=0x0001, GEN=1, pulse irq_src[0] → cpu_irq=1 with cpu_vector=0; cpu_ack → pending reads 0x0000, VECTOR reads 0x8000; EOI write → VECTOR reads 0x0000, cpu_irq stays 0.
- Priority: enable=0x00FF, irq_src[5] and irq_src[2] rise in the same cycle → vector=2; after ack+EOI → vector=5.
- Masking: enable=0, irq_src[3] rises → pending=0x0008, cpu_irq=0; write enable=0x0008 → cpu_irq=1 two cycles later, vector=3.
- Withdraw: in REQ for source 1, write PENDING=0x0002 → cpu_irq=0, state IDLE, no ack needed.
- Set-wins: W1C of bit 4 in the same cycle that irq_src[4] rises → pending bit 4 reads 1.
- Reset mid-REQ: drive reset_n low → cpu_irq=0 immediately; after release all registers read 0.
- Round-robin (IRQ_ROUND_ROBIN_EN): sources 0 and 1 held pending, re-raised after each service → grant order 0,1,0,1.
